// File: rtl/bus_io_fifo_peripheral_if.sv
// 8088 peripheral-side bus strobes and latched address.
// Data is a tristate and stays a plain top-level port.
interface bus_io_fifo_peripheral_if;
    logic [19:0] Address;
    logic        ALE;
    logic        RD;
    logic        WR;
    logic        IOM;

    modport master (
        output Address,
        output ALE,
        output RD,
        output WR,
        output IOM
    );

    modport slave (
        input Address,
        input ALE,
        input RD,
        input WR,
        input IOM
    );
endinterface

// File: rtl/bus_io_fifo_peripheral.sv
// I/O-mapped TX/RX FIFO peripheral on the 8088 bus.
// Four byte ports: DATA, STATUS, CTRL, reserved.
module bus_io_fifo_peripheral #(
    parameter logic [15:0] BASE_ADDR = 16'h0080,
    parameter int          DEPTH     = 16,
    parameter logic        IO_SEL    = 1'b1
) (
    input  logic                           CLK,
    input  logic                           RESET,
    bus_io_fifo_peripheral_if.slave        bus,
    inout  wire  [7:0]                     Data,
    output logic [7:0]                     tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    output logic                           rx_ready,
    output logic                           irq
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state;
    logic        sel;
    logic [1:0]  off;
    logic [7:0]  rd_q;
    logic [7:0]  wr_q;
    logic        rd_pop;
    logic        rd_unf;
    logic        ie;
    logic        tie;
    logic        tx_ovf;
    logic        rx_ovf;
    logic        rx_unf;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp;
    logic [AW-1:0] rx_wp, rx_rp;
    logic [CW-1:0] tx_cnt, rx_cnt;

    logic       tx_full, tx_empty;
    logic       rx_full, rx_empty;
    logic       hit;
    logic       wr_done, rd_done;
    logic       ctl_wr;
    logic       clr_fifo, clr_flag;
    logic       tx_pop, tx_push;
    logic       cpu_push, cpu_pop;
    logic       rx_push;
    logic       doe;
    logic [7:0] status;
    logic [7:0] rd_val;
    logic       unused_ok;

    assign tx_full  = (tx_cnt == FULL);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL);
    assign rx_empty = (rx_cnt == '0);

    assign hit = (bus.IOM == IO_SEL) &&
                 (bus.Address[15:2] == BASE_ADDR[15:2]);

    assign wr_done  = (state == S_WRITE) && bus.WR;
    assign rd_done  = (state == S_READ) && bus.RD;
    assign cpu_push = wr_done && (off == 2'd0);
    assign ctl_wr   = wr_done && (off == 2'd2);
    assign clr_fifo = ctl_wr && wr_q[0];
    assign clr_flag = ctl_wr && wr_q[1];

    assign tx_pop  = tx_valid && tx_ready;
    assign tx_push = cpu_push && (!tx_full || tx_pop);
    assign cpu_pop = rd_done && rd_pop;
    assign rx_push = rx_valid && (!rx_full || cpu_pop);

    assign status = {1'b0, tx_ovf, rx_unf, rx_ovf,
                     tx_empty, tx_full, rx_full, !rx_empty};

    always_comb begin
        rd_val = 8'h00;
        case (off)
            2'd0:    rd_val = rx_empty ? 8'h00 : rx_mem[rx_rp];
            2'd1:    rd_val = status;
            2'd2:    rd_val = {4'h0, tie, ie, 2'b00};
            default: rd_val = 8'h00;
        endcase
    end

    // Release is combinational so RD high or RESET floats the bus at once.
    assign doe  = (state == S_READ) && !bus.RD;
    assign Data = doe ? rd_q : 8'hzz;

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rp];
    assign rx_ready = !rx_full;
    assign irq      = (ie && !rx_empty) || (tie && tx_empty);

    assign unused_ok = ^{bus.Address[19:16], wr_q[7:4]};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= S_IDLE;
            sel    <= 1'b0;
            off    <= 2'd0;
            rd_q   <= 8'h00;
            wr_q   <= 8'h00;
            rd_pop <= 1'b0;
            rd_unf <= 1'b0;
            ie     <= 1'b0;
            tie    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.ALE) begin
                        sel   <= hit;
                        off   <= bus.Address[1:0];
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus.ALE) begin
                        sel <= hit;
                        off <= bus.Address[1:0];
                    end else if (!bus.RD) begin
                        if (sel) begin
                            state  <= S_READ;
                            rd_q   <= rd_val;
                            rd_pop <= (off == 2'd0) && !rx_empty;
                            rd_unf <= (off == 2'd0) && rx_empty;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (!bus.WR) begin
                        if (sel) begin
                            state <= S_WRITE;
                            wr_q  <= Data;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_READ: begin
                    if (bus.RD) state <= S_IDLE;
                end
                S_WRITE: begin
                    if (bus.WR) begin
                        state <= S_IDLE;
                        if (off == 2'd2) begin
                            ie  <= wr_q[2];
                            tie <= wr_q[3];
                        end
                    end else begin
                        wr_q <= Data;
                    end
                end
            endcase
        end
    end

    // Storage needs no reset; pointers and counts define validity.
    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wp] <= wr_q;
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else if (clr_fifo) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (cpu_pop) rx_rp <= rx_rp + AW'(1);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(cpu_pop);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else if (clr_flag) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            if (cpu_push && !tx_push)  tx_ovf <= 1'b1;
            if (rx_valid && !rx_push)  rx_ovf <= 1'b1;
            if (rd_done && rd_unf)     rx_unf <= 1'b1;
        end
    end

endmodule
